// File: rtl/interrupt_ack_sequencer_pkg.sv
// Shared 8259A definitions: acknowledge FSM states, field widths and the
// fixed-priority lowest-set-bit helper also used by the priority resolver.
package pic_pkg;

  localparam int LEVEL_W    = 3;
  localparam int VEC_BASE_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK1  = 2'd1,
    WAIT2 = 2'd2,
    ACK2  = 2'd3
  } ack_state_e;

  // IR0 is highest priority, so scan downward and keep the last hit.
  function automatic logic [LEVEL_W-1:0] lowest_set_index(input logic [7:0] v);
    logic [LEVEL_W-1:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        idx = LEVEL_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_if.sv
// CPU-side INT/INTA bundle of the PIC; slave is the sequencer, master the
// CPU/resolver environment that drives it.
interface interrupt_ack_sequencer_if;
  import pic_pkg::*;

  logic                  INTA_n;
  logic                  int_req;
  logic [LEVEL_W-1:0]    ir_level;
  logic [VEC_BASE_W-1:0] ICW2_T;
  logic                  AEOI;
  logic                  eoi_nonspec;
  logic                  eoi_spec;
  logic [LEVEL_W-1:0]    eoi_level;
  logic                  INT;
  logic [7:0]            ISR;
  logic                  ack_pulse;
  logic [LEVEL_W-1:0]    ack_level;
  logic [7:0]            data_out;
  logic                  data_oe;

  modport slave (
    input  INTA_n, int_req, ir_level, ICW2_T, AEOI, eoi_nonspec, eoi_spec, eoi_level,
    output INT, ISR, ack_pulse, ack_level, data_out, data_oe
  );

  modport master (
    output INTA_n, int_req, ir_level, ICW2_T, AEOI, eoi_nonspec, eoi_spec, eoi_level,
    input  INT, ISR, ack_pulse, ack_level, data_out, data_oe
  );

endinterface

// File: rtl/interrupt_ack_sequencer_inta_edge_sync.sv
// INTA_n synchronizer with registered one-cycle fall/rise strobes; all flops
// preset to the idle-high level so reset never produces a spurious edge.
module inta_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic inta_n,
  output logic fall,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   last_r;
  logic                   fall_r;
  logic                   rise_r;

  // Synchronizer chain, previous-value flop and edge strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= '1;
      last_r <= 1'b1;
      fall_r <= 1'b0;
      rise_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], inta_n};
      last_r <= sync_r[SYNC_STAGES-1];
      fall_r <= last_r & ~sync_r[SYNC_STAGES-1];
      rise_r <= ~last_r & sync_r[SYNC_STAGES-1];
    end
  end

  assign fall = fall_r;
  assign rise = rise_r;

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8086-mode two-pulse INTA sequencer of the 8259A: forwards INT, latches the
// acknowledged level, drives the vector byte and owns the In-Service Register.
module interrupt_ack_sequencer
  import pic_pkg::*;
#(
  parameter int                 SYNC_STAGES    = 2,
  parameter logic [LEVEL_W-1:0] SPURIOUS_LEVEL = 3'd7
) (
  input logic                      clk,
  input logic                      reset,
  interrupt_ack_sequencer_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ACK1  = ACK1;
  localparam logic [1:0] ST_WAIT2 = WAIT2;
  localparam logic [1:0] ST_ACK2  = ACK2;

  logic               fall_s, rise_s;
  logic [1:0]         state_r, state_s;
  logic               int_r, int_s;
  logic [7:0]         isr_r, isr_s;
  logic               ack_pulse_r, ack_pulse_s;
  logic [LEVEL_W-1:0] ack_level_r, ack_level_s;
  logic [7:0]         data_out_r, data_out_s;
  logic               data_oe_r, data_oe_s;
  logic               spurious_r, spurious_s;
  logic [7:0]         set_mask_s, aeoi_mask_s, eoi_mask_s;

  inta_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .inta_n (bus.INTA_n),
    .fall   (fall_s),
    .rise   (rise_s)
  );

  // Acknowledge FSM next-state and per-event ISR set/clear masks.
  always_comb begin
    state_s     = state_r;
    ack_pulse_s = 1'b0;
    ack_level_s = ack_level_r;
    data_out_s  = data_out_r;
    data_oe_s   = data_oe_r;
    spurious_s  = spurious_r;
    set_mask_s  = 8'h00;
    aeoi_mask_s = 8'h00;
    case (state_r)
      ST_IDLE: begin
        if (fall_s) begin
          state_s = ST_ACK1;
          if (bus.int_req) begin
            ack_level_s = bus.ir_level;
            set_mask_s  = 8'd1 << bus.ir_level;
            ack_pulse_s = 1'b1;
            spurious_s  = 1'b0;
          end else begin
            ack_level_s = SPURIOUS_LEVEL;
            spurious_s  = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACK1: begin
        if (rise_s) begin
          state_s = ST_WAIT2;
        end else begin
          state_s = ST_ACK1;
        end
      end
      ST_WAIT2: begin
        if (fall_s) begin
          state_s    = ST_ACK2;
          data_out_s = {bus.ICW2_T, ack_level_r};
          data_oe_s  = 1'b1;
        end else begin
          state_s = ST_WAIT2;
        end
      end
      ST_ACK2: begin
        if (rise_s) begin
          state_s   = ST_IDLE;
          data_oe_s = 1'b0;
          if (bus.AEOI && !spurious_r) begin
            aeoi_mask_s = 8'd1 << ack_level_r;
          end else begin
            aeoi_mask_s = 8'h00;
          end
        end else begin
          state_s = ST_ACK2;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        data_oe_s = 1'b0;
      end
    endcase
  end

  // EOI clear mask: specific wins; non-specific picks the highest-priority bit.
  always_comb begin
    if (bus.eoi_spec) begin
      eoi_mask_s = 8'd1 << bus.eoi_level;
    end else if (bus.eoi_nonspec && (isr_r != 8'h00)) begin
      eoi_mask_s = 8'd1 << lowest_set_index(isr_r);
    end else begin
      eoi_mask_s = 8'h00;
    end
  end

  // Clears act on the pre-set ISR so a bit set this cycle always survives.
  always_comb begin
    isr_s = (isr_r & ~(eoi_mask_s | aeoi_mask_s)) | set_mask_s;
    if (state_s == ST_IDLE) begin
      int_s = bus.int_req;
    end else begin
      int_s = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      int_r       <= 1'b0;
      isr_r       <= 8'h00;
      ack_pulse_r <= 1'b0;
      ack_level_r <= 3'd0;
      data_out_r  <= 8'h00;
      data_oe_r   <= 1'b0;
      spurious_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      int_r       <= int_s;
      isr_r       <= isr_s;
      ack_pulse_r <= ack_pulse_s;
      ack_level_r <= ack_level_s;
      data_out_r  <= data_out_s;
      data_oe_r   <= data_oe_s;
      spurious_r  <= spurious_s;
    end
  end

  assign bus.INT       = int_r;
  assign bus.ISR       = isr_r;
  assign bus.ack_pulse = ack_pulse_r;
  assign bus.ack_level = ack_level_r;
  assign bus.data_out  = data_out_r;
  assign bus.data_oe   = data_oe_r;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed bench for interrupt_ack_sequencer: two-pulse INTA cycles, AEOI,
// spurious acknowledge, EOI handling and reset during the vector phase.
module tb_interrupt_ack_sequencer;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   pulse_cnt;
  int   oe_cnt;

  interrupt_ack_sequencer_if bus();

  interrupt_ack_sequencer #(.SYNC_STAGES(2), .SPURIOUS_LEVEL(3'd7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Holds INTA_n at lvl for a number of cycles, tallying ack pulses and drive cycles.
  task automatic phase(input logic lvl, input int cycles);
    bus.INTA_n = lvl;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.ack_pulse === 1'b1) pulse_cnt++;
      if (bus.data_oe === 1'b1) oe_cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.INTA_n = 1'b1; bus.int_req = 1'b0; bus.ir_level = 3'd0; bus.ICW2_T = 5'd0;
    bus.AEOI = 1'b0; bus.eoi_nonspec = 1'b0; bus.eoi_spec = 1'b0; bus.eoi_level = 3'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Complete acknowledge of one level, request withdrawn after the first pulse.
  task automatic ack_full(input logic [2:0] lvl);
    bus.int_req = 1'b1; bus.ir_level = lvl;
    phase(1'b0, 6);
    bus.int_req = 1'b0;
    phase(1'b1, 6); phase(1'b0, 6); phase(1'b1, 6);
  endtask

  task automatic eoi_pulse(input logic spec, input logic nonspec, input logic [2:0] lvl);
    bus.eoi_spec = spec; bus.eoi_nonspec = nonspec; bus.eoi_level = lvl;
    @(negedge clk);
    bus.eoi_spec = 1'b0; bus.eoi_nonspec = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    total++; if (bus.INT !== 1'b0) begin bad++; $display("FAIL reset_int got=%0h want=0", bus.INT); end
    total++; if (bus.ISR !== 8'h00) begin bad++; $display("FAIL reset_isr got=%0h want=00", bus.ISR); end
    total++; if (bus.ack_pulse !== 1'b0) begin bad++; $display("FAIL reset_ack_pulse got=%0h want=0", bus.ack_pulse); end
    total++; if (bus.ack_level !== 3'd0) begin bad++; $display("FAIL reset_ack_level got=%0h want=0", bus.ack_level); end
    total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out got=%0h want=00", bus.data_out); end
    total++; if (bus.data_oe !== 1'b0) begin bad++; $display("FAIL reset_data_oe got=%0h want=0", bus.data_oe); end
  endtask

  task automatic test_basic_ack();
    do_reset();
    bus.ICW2_T = 5'b01000; bus.int_req = 1'b1; bus.ir_level = 3'd3;
    repeat (3) @(negedge clk);
    total++; if (bus.INT !== 1'b1) begin bad++; $display("FAIL basic_int_pre got=%0h want=1", bus.INT); end
    pulse_cnt = 0; oe_cnt = 0;
    phase(1'b0, 6);
    total++; if (pulse_cnt !== 1) begin bad++; $display("FAIL basic_pulse_cnt got=%0d want=1", pulse_cnt); end
    total++; if (bus.ack_level !== 3'd3) begin bad++; $display("FAIL basic_ack_level got=%0h want=3", bus.ack_level); end
    total++; if (bus.ISR !== 8'h08) begin bad++; $display("FAIL basic_isr1 got=%0h want=08", bus.ISR); end
    total++; if (bus.INT !== 1'b0) begin bad++; $display("FAIL basic_int_ack1 got=%0h want=0", bus.INT); end
    phase(1'b1, 6);
    total++; if (oe_cnt !== 0) begin bad++; $display("FAIL basic_oe_early got=%0d want=0", oe_cnt); end
    total++; if (bus.INT !== 1'b0) begin bad++; $display("FAIL basic_int_wait2 got=%0h want=0", bus.INT); end
    phase(1'b0, 6);
    total++; if (bus.data_oe !== 1'b1) begin bad++; $display("FAIL basic_oe got=%0h want=1", bus.data_oe); end
    total++; if (bus.data_out !== 8'h43) begin bad++; $display("FAIL basic_vector got=%0h want=43", bus.data_out); end
    total++; if (pulse_cnt !== 1) begin bad++; $display("FAIL basic_pulse_cnt2 got=%0d want=1", pulse_cnt); end
    phase(1'b1, 6);
    total++; if (bus.data_oe !== 1'b0) begin bad++; $display("FAIL basic_oe_off got=%0h want=0", bus.data_oe); end
    total++; if (bus.data_out !== 8'h43) begin bad++; $display("FAIL basic_vector_hold got=%0h want=43", bus.data_out); end
    total++; if (bus.ISR !== 8'h08) begin bad++; $display("FAIL basic_isr_end got=%0h want=08", bus.ISR); end
    total++; if (bus.INT !== 1'b1) begin bad++; $display("FAIL basic_int_post got=%0h want=1", bus.INT); end
    bus.int_req = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.INT !== 1'b0) begin bad++; $display("FAIL basic_int_follow got=%0h want=0", bus.INT); end
  endtask

  task automatic test_aeoi();
    do_reset();
    bus.ICW2_T = 5'b01000; bus.AEOI = 1'b1; bus.int_req = 1'b1; bus.ir_level = 3'd3;
    repeat (3) @(negedge clk);
    phase(1'b0, 6);
    total++; if (bus.ISR !== 8'h08) begin bad++; $display("FAIL aeoi_isr_set got=%0h want=08", bus.ISR); end
    bus.int_req = 1'b0;
    phase(1'b1, 6); phase(1'b0, 6);
    total++; if (bus.ISR !== 8'h08) begin bad++; $display("FAIL aeoi_isr_ack2 got=%0h want=08", bus.ISR); end
    phase(1'b1, 3);
    total++; if (bus.ISR !== 8'h08) begin bad++; $display("FAIL aeoi_isr_pre_rise got=%0h want=08", bus.ISR); end
    @(negedge clk);
    total++; if (bus.ISR !== 8'h00) begin bad++; $display("FAIL aeoi_isr_clear got=%0h want=00", bus.ISR); end
  endtask

  task automatic test_spurious();
    do_reset();
    bus.ICW2_T = 5'b01000; bus.int_req = 1'b1; bus.ir_level = 3'd2;
    repeat (3) @(negedge clk);
    bus.int_req = 1'b0;
    repeat (2) @(negedge clk);
    pulse_cnt = 0;
    phase(1'b0, 6);
    total++; if (pulse_cnt !== 0) begin bad++; $display("FAIL spur_pulse_cnt got=%0d want=0", pulse_cnt); end
    total++; if (bus.ISR !== 8'h00) begin bad++; $display("FAIL spur_isr got=%0h want=00", bus.ISR); end
    total++; if (bus.ack_level !== 3'd7) begin bad++; $display("FAIL spur_level got=%0h want=7", bus.ack_level); end
    phase(1'b1, 6); phase(1'b0, 6);
    total++; if (bus.data_out !== 8'h47) begin bad++; $display("FAIL spur_vector got=%0h want=47", bus.data_out); end
    total++; if (bus.data_oe !== 1'b1) begin bad++; $display("FAIL spur_oe got=%0h want=1", bus.data_oe); end
    phase(1'b1, 6);
    // A spurious acknowledge in AEOI mode must not clear a genuine IR7.
    ack_full(3'd7);
    total++; if (bus.ISR !== 8'h80) begin bad++; $display("FAIL spur_preload got=%0h want=80", bus.ISR); end
    bus.AEOI = 1'b1;
    phase(1'b0, 6); phase(1'b1, 6); phase(1'b0, 6); phase(1'b1, 6);
    total++; if (bus.ISR !== 8'h80) begin bad++; $display("FAIL spur_aeoi_keep got=%0h want=80", bus.ISR); end
  endtask

  task automatic test_eoi();
    do_reset();
    ack_full(3'd3); ack_full(3'd5);
    total++; if (bus.ISR !== 8'h28) begin bad++; $display("FAIL eoi_preload got=%0h want=28", bus.ISR); end
    eoi_pulse(1'b1, 1'b0, 3'd2);
    total++; if (bus.ISR !== 8'h28) begin bad++; $display("FAIL eoi_spec_clear_lvl got=%0h want=28", bus.ISR); end
    eoi_pulse(1'b0, 1'b1, 3'd0);
    total++; if (bus.ISR !== 8'h20) begin bad++; $display("FAIL eoi_nonspec got=%0h want=20", bus.ISR); end
    eoi_pulse(1'b1, 1'b0, 3'd5);
    total++; if (bus.ISR !== 8'h00) begin bad++; $display("FAIL eoi_spec5 got=%0h want=00", bus.ISR); end
    ack_full(3'd3); ack_full(3'd5);
    eoi_pulse(1'b1, 1'b1, 3'd5);
    total++; if (bus.ISR !== 8'h08) begin bad++; $display("FAIL eoi_precedence got=%0h want=08", bus.ISR); end
    eoi_pulse(1'b0, 1'b1, 3'd0);
    eoi_pulse(1'b0, 1'b1, 3'd0);
    total++; if (bus.ISR !== 8'h00) begin bad++; $display("FAIL eoi_nonspec_empty got=%0h want=00", bus.ISR); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    ack_full(3'd3);
    bus.int_req = 1'b1; bus.ir_level = 3'd1;
    bus.INTA_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.eoi_nonspec = 1'b1;
    @(negedge clk);
    bus.eoi_nonspec = 1'b0;
    total++; if (bus.ISR !== 8'h02) begin bad++; $display("FAIL simul_isr got=%0h want=02", bus.ISR); end
    bus.int_req = 1'b0;
    phase(1'b0, 3); phase(1'b1, 6); phase(1'b0, 6);
    total++; if (bus.data_out !== 8'h01) begin bad++; $display("FAIL simul_vector got=%0h want=01", bus.data_out); end
    phase(1'b1, 6);
  endtask

  task automatic test_reset_midcycle();
    do_reset();
    bus.ICW2_T = 5'b01000; bus.int_req = 1'b1; bus.ir_level = 3'd3;
    repeat (3) @(negedge clk);
    phase(1'b0, 6);
    bus.int_req = 1'b0;
    phase(1'b1, 6); phase(1'b0, 6);
    total++; if (bus.data_oe !== 1'b1) begin bad++; $display("FAIL rst_mid_oe_before got=%0h want=1", bus.data_oe); end
    reset = 1'b1; bus.INTA_n = 1'b1;
    #1;
    total++; if (bus.data_oe !== 1'b0) begin bad++; $display("FAIL rst_mid_oe_async got=%0h want=0", bus.data_oe); end
    total++; if (bus.ISR !== 8'h00) begin bad++; $display("FAIL rst_mid_isr got=%0h want=00", bus.ISR); end
    total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL rst_mid_data_out got=%0h want=00", bus.data_out); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus.ICW2_T = 5'b10101; bus.int_req = 1'b1; bus.ir_level = 3'd6;
    repeat (3) @(negedge clk);
    total++; if (bus.INT !== 1'b1) begin bad++; $display("FAIL rst_mid_int got=%0h want=1", bus.INT); end
    pulse_cnt = 0;
    phase(1'b0, 6);
    total++; if (pulse_cnt !== 1) begin bad++; $display("FAIL rst_mid_pulse got=%0d want=1", pulse_cnt); end
    total++; if (bus.ISR !== 8'h40) begin bad++; $display("FAIL rst_mid_isr_set got=%0h want=40", bus.ISR); end
    bus.int_req = 1'b0;
    phase(1'b1, 6); phase(1'b0, 6);
    total++; if (bus.data_out !== 8'hAE) begin bad++; $display("FAIL rst_mid_vector got=%0h want=ae", bus.data_out); end
    phase(1'b1, 6);
    total++; if (bus.data_oe !== 1'b0) begin bad++; $display("FAIL rst_mid_oe_end got=%0h want=0", bus.data_oe); end
  endtask

  initial begin
    total = 0; bad = 0; pulse_cnt = 0; oe_cnt = 0;
    reset = 1'b1;
    bus.INTA_n = 1'b1; bus.int_req = 1'b0; bus.ir_level = 3'd0; bus.ICW2_T = 5'd0;
    bus.AEOI = 1'b0; bus.eoi_nonspec = 1'b0; bus.eoi_spec = 1'b0; bus.eoi_level = 3'd0;
    test_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_basic_ack();
    test_aeoi();
    test_spurious();
    test_eoi();
    test_simultaneous();
    test_reset_midcycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interrupt_ack_sequencer.md
Name: interrupt_ack_sequencer

Overview:
- CPU-facing end of the priority resolver's INT/INTA interface in the 8259A PIC.
- Forwards resolver interrupt requests to the CPU and runs the 8086-mode two-pulse INTA acknowledge cycle:
  - 1st pulse: latches the winning IR level and sets its ISR bit.
  - 2nd pulse: drives the vector byte onto the data bus.
- Owns the In-Service Register, including EOI and AEOI clearing.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for INTA_n.
- SPURIOUS_LEVEL, 7, IR level reported when the request vanishes before the 1st INTA.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- INTA_n  input  1  CPU interrupt acknowledge, active-low, asynchronous to clk.
- int_req  input  1  INT from priority resolver (unmasked request pending).
- ir_level  input  3  highest-priority pending level from resolver.
- ICW2_T  input  5  vector base bits T7..T3.
- AEOI  input  1  automatic EOI mode enable.
- eoi_nonspec  input  1  one-cycle pulse: non-specific EOI.
- eoi_spec  input  1  one-cycle pulse: specific EOI.
- eoi_level  input  3  level for specific EOI.
- INT  output  1  interrupt request to CPU.
- ISR  output  8  In-Service Register.
- ack_pulse  output  1  one-cycle pulse at 1st INTA fall; tells resolver to clear IRR[ack_level].
- ack_level  output  3  latched level.
- data_out  output  8  vector byte.
- data_oe  output  1  data bus drive enable.

Behaviour:
- Reset (async, any state): state=IDLE, INT=0, ISR=0, ack_pulse=0, ack_level=0, data_out=0, data_oe=0. Synchronizer flops are preset to 1 (INTA_n idle).
- INTA_n passes through a SYNC_STAGES-flop synchronizer plus an edge detector. fall/rise are one-cycle strobes; the FSM reacts on the strobe cycle and its outputs register one cycle later.
- INT = registered int_req while state==IDLE. Forced 0 from the 1st fall until return to IDLE.
- FSM states: IDLE, ACK1, WAIT2, ACK2.
- IDLE --fall--> ACK1:
  - If int_req=1: latch ack_level=ir_level, set ISR[ir_level], pulse ack_pulse.
  - If int_req=0 (spurious): ack_level=SPURIOUS_LEVEL, ISR unchanged, no ack_pulse.
- ACK1 --rise--> WAIT2.
- WAIT2 --fall--> ACK2: data_out={ICW2_T, ack_level}, data_oe=1.
- ACK2 --rise--> IDLE: data_oe=0, data_out holds.
  - If AEOI=1 and the acknowledge was not spurious: clear ISR[ack_level] on the same cycle.
- A rise seen in IDLE, or a fall seen in ACK1/ACK2, is ignored. No timeout: WAIT2 waits indefinitely.
- Non-specific EOI: clears the lowest-index set ISR bit (fixed priority, IR0 highest). No effect if ISR=0.
- Specific EOI: clears ISR[eoi_level]. No effect if already 0.
- Both EOI pulses in the same cycle: specific takes precedence, non-specific is dropped.
- EOI coincident with an ISR set (1st fall): the clear is computed on the pre-set ISR value, then the set is applied. The newly set bit always survives.
- EOI coincident with an AEOI clear: both clears apply.
- ISR updates are registered; ISR is visible the cycle after the event.
- int_req/ir_level changes after ACK1 do not affect ack_level or the vector.
- Reset during ACK2 drops data_oe asynchronously.

Decomposition:
- Package pic_pkg holds:
  - FSM state enum (IDLE, ACK1, WAIT2, ACK2).
  - LEVEL_W=3 and VEC_BASE_W=5 constants.
  - Function lowest_set_index(8-bit) → 3-bit, shared with the priority resolver.
- Sub-module inta_edge_sync: SYNC_STAGES synchronizer plus fall/rise strobe generation. Reset value 1.

Test Plan:
- Basic ack: int_req=1, ir_level=3, ICW2_T=5'b01000, AEOI=0, two INTA_n pulses → INT=1 before the 1st fall, then INT=0; ack_pulse once with ack_level=3; ISR=8'h08; data_out=8'h43 with data_oe=1 during the 2nd pulse only; after the 2nd rise ISR stays 8'h08 and INT follows int_req.
- AEOI: same stimulus with AEOI=1 → ISR=8'h08 after the 1st fall, 8'h00 the cycle after the 2nd rise.
- Spurious: int_req drops before the 1st fall → no ack_pulse, ISR=8'h00, 2nd pulse drives {ICW2_T,3'b111}=8'h47.
- EOI: ISR preloaded 8'h28 via two acks (levels 3, 5):
  - Non-specific EOI → 8'h20.
  - Specific EOI level 5 → 8'h00.
  - Specific EOI on a clear level 2 → unchanged.
- Simultaneous: non-specific EOI in the same cycle as the 1st-fall set of level 1, ISR=8'h08 beforehand → ISR=8'h02.
- Reset mid-cycle: assert reset during ACK2 → data_oe=0 immediately, ISR=0, state IDLE. A following clean two-pulse sequence completes normally.
